// File: rtl/sm_hex_display_mux_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   GLYPH        : active-high a..g patterns for hex digits 0-F (bit 0 = a).
//   SEG_ALL      : all seven segments.
//   seg_pol()    : map an active-high glyph onto pin polarity.
//   scan_div_ok(): legality of the per-digit slot length.
package sm_hex_display_mux_pkg;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  localparam logic [6:0] SEG_ALL = 7'h7F;

  function automatic logic [6:0] seg_pol(input logic [6:0] g, input bit active_low);
    return active_low ? ~g : g;
  endfunction

  // Slot must split into 16 equal brightness steps.
  function automatic bit scan_div_ok(input int d);
    return (d >= 16) && (d % 16 == 0);
  endfunction

endpackage

// File: rtl/sm_hex_display.sv
// Hex nibble to seven-segment glyph decoder (pure combinational).
//   nib   : 4-bit hex value
//   glyph : active-high segments, glyph[0]=a .. glyph[6]=g
module sm_hex_display
  import sm_hex_display_mux_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  assign glyph = GLYPH[nib];

endmodule

// File: rtl/sm_hex_display_mux.sv
// Time-multiplexed N-digit seven-segment driver.
//   clk, rst   : clock, synchronous active-high reset
//   en         : scan enable (0 freezes the scan and darkens the display)
//   load       : strobe capturing value/dp into the pending register
//   value, dp  : hex nibbles (nibble 0 = rightmost) and decimal points
//   brightness : 0 dimmest .. 15 full
//   seg, seg_dp: segment / decimal-point pins (registered, pin polarity)
//   dig_sel    : one-hot digit select (registered, pin polarity)
//   frame_done : one-cycle pulse when the scan wraps back to digit 0
module sm_hex_display_mux
  import sm_hex_display_mux_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  if (!scan_div_ok(SCAN_DIV) || DIGITS < 1 || DIGITS > 8) begin : g_bad_param
    $error("sm_hex_display_mux: illegal DIGITS/SCAN_DIV");
  end

  localparam int CW   = $clog2(SCAN_DIV);
  localparam int TW   = $clog2(SCAN_DIV + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STEP = SCAN_DIV / 16;

  localparam logic [6:0]        SEG_OFF = seg_pol(7'h00, SEG_ACTIVE_LOW);
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [TW-1:0]            thr, thr_next;
  logic [DIGITS-1:0][3:0]   pend_val, disp_val;
  logic [DIGITS-1:0]        pend_dp, disp_dp;
  logic [DIGITS-1:0]        blank;
  logic                     zero_above;
  logic                     slot_end, frame_wrap, lit;
  logic [3:0]               cur_nib;
  logic [6:0]               glyph;
  logic [DIGITS-1:0]        onehot;

  assign slot_end   = (cnt == CW'(SCAN_DIV - 1));
  assign frame_wrap = en && slot_end && (idx == IW'(DIGITS - 1));
  assign thr_next   = TW'((int'(brightness) + 1) * STEP);

  // A digit is blanked only if every digit above it is blanked too, so a
  // lit dp on a higher zero digit keeps the zeros below it visible.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      blank[k]   = BLANK_LEADING && zero_above && (disp_val[k] == 4'h0) && !disp_dp[k];
      zero_above = blank[k];
    end
  end

  assign cur_nib = disp_val[idx];
  assign onehot  = DIGITS'(1) << idx;

  // cnt == 0 is dead time between digits to avoid ghosting.
  assign lit = en && (cnt != '0) && (TW'(cnt) < thr) && !blank[idx];

  sm_hex_display u_dec (
    .nib   (cur_nib),
    .glyph (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      thr        <= TW'(STEP);
      pend_val   <= '0;
      pend_dp    <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      seg        <= SEG_OFF;
      seg_dp     <= SEG_ACTIVE_LOW;
      dig_sel    <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp;
      end
      if (en) begin
        if (cnt == '0) thr <= thr_next;
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // Display only changes on frame boundaries; a coincident load bypasses pending.
      if (frame_wrap) begin
        disp_val <= load ? value : pend_val;
        disp_dp  <= load ? dp    : pend_dp;
      end
      frame_done <= frame_wrap;
      seg        <= lit ? seg_pol(glyph, SEG_ACTIVE_LOW) : SEG_OFF;
      seg_dp     <= lit ? (disp_dp[idx] ^ SEG_ACTIVE_LOW) : SEG_ACTIVE_LOW;
      dig_sel    <= lit ? (onehot ^ DIG_OFF) : DIG_OFF;
    end
  end

endmodule

// File: tb/tb_sm_hex_display_mux.sv
module tb_sm_hex_display_mux;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int p = 0;  // slot position idx*16+cnt currently held in the DUT

  always #5 clk = ~clk;

  sm_hex_display_mux #(
    .DIGITS(4), .SCAN_DIV(16), .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp(dp),
    .brightness(brightness), .seg(seg), .seg_dp(seg_dp),
    .dig_sel(dig_sel), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) p = 0;
    else if (en) p = (p + 1) % 64;
  endtask

  // Advance until the outputs reflect slot position (i, c).
  task automatic see(input int i, input int c);
    int n;
    n = (((i * 16 + c) - p) % 64 + 64) % 64 + 1;
    repeat (n) tick();
  endtask

  // Advance until the DUT currently holds position t.
  task automatic goto_pos(input int t);
    for (int k = 0; k < 70 && p != t; k++) tick();
  endtask

  task automatic wait_frame(output int cycles);
    bit found;
    found = 1'b0;
    cycles = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      cycles++;
      if (frame_done === 1'b1) found = 1'b1;
    end
    chk("frame_timeout", {31'd0, found}, 32'd1);
    p = 0;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] d, input logic [6:0] s, input logic sdp);
    chk({tag, "_dig"}, {28'd0, dig_sel}, {28'd0, d});
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, s});
    chk({tag, "_dp"},  {31'd0, seg_dp}, {31'd0, sdp});
  endtask

  initial begin
    int cyc;
    int bad;
    rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0; dp = 4'h0; brightness = 4'd15;
    repeat (3) tick();
    chk_out("reset", 4'hF, 7'h7F, 1'b1);
    chk("reset_fd", {31'd0, frame_done}, 32'd0);

    // Release, enable and load 00A5 in the first slot.
    rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h00A5; dp = 4'h0;
    tick();
    load = 1'b0;
    wait_frame(cyc);
    wait_frame(cyc);
    chk("frame_period", cyc, 64);

    see(0, 0);  chk_out("a5_dead", 4'hF, 7'h7F, 1'b1);
    see(0, 1);  chk_out("a5_d0",   4'b1110, 7'h12, 1'b1);
    see(0, 15); chk_out("a5_d0_end", 4'b1110, 7'h12, 1'b1);
    see(1, 5);  chk_out("a5_d1",   4'b1101, 7'h08, 1'b1);
    see(2, 5);  chk_out("a5_d2_blank", 4'hF, 7'h7F, 1'b1);
    see(3, 5);  chk_out("a5_d3_blank", 4'hF, 7'h7F, 1'b1);

    // Mid-frame load must not show until the frame wraps.
    goto_pos(21);
    load = 1'b1; value = 16'h1234; tick(); load = 1'b0;
    see(2, 5);  chk_out("mid_d2_old", 4'hF, 7'h7F, 1'b1);
    see(3, 5);  chk_out("mid_d3_old", 4'hF, 7'h7F, 1'b1);
    wait_frame(cyc);
    see(0, 3);  chk_out("n1234_d0", 4'b1110, 7'h19, 1'b1);
    see(1, 3);  chk_out("n1234_d1", 4'b1101, 7'h30, 1'b1);
    see(2, 3);  chk_out("n1234_d2", 4'b1011, 7'h24, 1'b1);
    see(3, 3);  chk_out("n1234_d3", 4'b0111, 7'h79, 1'b1);

    // Load coinciding with the wrap goes straight to the display.
    goto_pos(63);
    load = 1'b1; value = 16'hC0DE; tick(); load = 1'b0;
    chk("wrap_fd", {31'd0, frame_done}, 32'd1);
    see(0, 1);  chk_out("wrap_d0_E", 4'b1110, 7'h06, 1'b1);

    // Brightness 3: lit only cnt 1..3.
    brightness = 4'd3;
    see(1, 0);  chk_out("b3_c0", 4'hF, 7'h7F, 1'b1);
    see(1, 1);  chk_out("b3_c1", 4'b1101, 7'h21, 1'b1);
    see(1, 3);  chk_out("b3_c3", 4'b1101, 7'h21, 1'b1);
    see(1, 4);  chk_out("b3_c4", 4'hF, 7'h7F, 1'b1);
    brightness = 4'd15;

    // All zeros with dp on digit 2 stops blanking below it.
    load = 1'b1; value = 16'h0000; dp = 4'b0100; tick(); load = 1'b0;
    wait_frame(cyc);
    see(0, 5);  chk_out("z_d0", 4'b1110, 7'h40, 1'b1);
    see(1, 5);  chk_out("z_d1", 4'b1101, 7'h40, 1'b1);
    see(2, 5);  chk_out("z_d2", 4'b1011, 7'h40, 1'b0);
    see(3, 5);  chk_out("z_d3", 4'hF, 7'h7F, 1'b1);

    // Freeze at cnt=7 of digit 0 for 20 cycles.
    goto_pos(7);
    en = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (dig_sel !== 4'hF || seg !== 7'h7F || seg_dp !== 1'b1 || frame_done !== 1'b0) bad++;
    end
    chk("hold_dark", bad, 0);
    en = 1'b1;
    see(0, 7);  chk_out("resume_c7", 4'b1110, 7'h40, 1'b1);
    see(1, 0);  chk_out("resume_next_dead", 4'hF, 7'h7F, 1'b1);
    see(1, 1);  chk_out("resume_d1", 4'b1101, 7'h40, 1'b1);

    // Reset mid-slot with a pending load outstanding.
    goto_pos(37);
    load = 1'b1; value = 16'h1111; dp = 4'h0; tick(); load = 1'b0;
    rst = 1'b1; tick();
    chk_out("rst_mid", 4'hF, 7'h7F, 1'b1);
    chk("rst_mid_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    see(0, 1);  chk_out("rst_idx0", 4'b1110, 7'h40, 1'b1);
    wait_frame(cyc);
    see(1, 1);  chk_out("rst_pend_gone", 4'hF, 7'h7F, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sm_hex_display_mux.md
# sm_hex_display_mux

Parametrised, time-multiplexed driver for an N-digit common-cathode or common-anode seven-segment indicator. Scans one digit at a time at a programmable rate, with per-digit decimal points, leading-zero blanking, 16-level brightness PWM and tear-free value updates applied only at frame boundaries. Sits between the core's debug/register output and the board GPIO segment/digit pins, replacing per-board hand-wired blink logic.

## Interface
- DIGITS, 4: number of digits scanned (1..8).
- SCAN_DIV, 50000: clock cycles per digit slot; multiple of 16, ≥ 16.
- SEG_ACTIVE_LOW, 1: 1 = segment/dp pins driven low when lit.
- DIG_ACTIVE_LOW, 1: 1 = digit-select pins driven low when selected.
- BLANK_LEADING, 1: 1 = leading-zero blanking enabled.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 freezes scan and darkens display.
- load  in  1  one-cycle strobe capturing value/dp into pending register.
- value  in  4*DIGITS  hex nibbles; nibble 0 = rightmost digit.
- dp  in  DIGITS  decimal point per digit.
- brightness  in  4  0 = dimmest, 15 = full.
- seg  out  7  segments, seg[0]=a … seg[6]=g, polarity per SEG_ACTIVE_LOW.
- seg_dp  out  1  decimal point, same polarity.
- dig_sel  out  DIGITS  one-hot digit select, polarity per DIG_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation
- Prescaler cnt counts 0..SCAN_DIV-1 while en=1; at SCAN_DIV-1 wraps to 0 and digit index idx advances, DIGITS-1 → 0 (frame wrap).
- Pending register: load=1 captures value/dp. Display register loads pending in the frame-wrap cycle. load coinciding with frame wrap: new value goes straight to display register.
- Brightness sampled into thr = (brightness+1)*(SCAN_DIV/16) when cnt=0. Digit lit while 1 ≤ cnt < thr; cnt=0 is dead time (all digits off) to suppress ghosting.
- Leading-zero blanking (BLANK_LEADING=1): digit k blanked when its nibble and all higher nibbles are 0 and its dp bit is 0; digit 0 never blanked. Blanked digit: dig_sel inactive for the whole slot.
- Decode: 0–F standard hex glyphs (0 = a..f lit = 7'b0111111 active-high; A = 7'b1110111; 5 = 7'b1101101).
- en=0: cnt and idx hold, seg/seg_dp/dig_sel inactive, frame_done 0; load still captured. en re-asserted resumes same slot at held cnt.
- Reset values: cnt=0, idx=0, pending=0, display=0, thr=SCAN_DIV/16; seg, seg_dp, dig_sel at inactive levels; frame_done=0.

## Timing
- All outputs registered: seg/seg_dp/dig_sel reflect cnt/idx of the previous cycle.
- Slot = SCAN_DIV cycles; frame = DIGITS*SCAN_DIV cycles; lit window per slot = thr-1 cycles.
- frame_done asserted the cycle after cnt=SCAN_DIV-1 with idx=DIGITS-1 (same edge the display register updates).
- load → visible latency: up to DIGITS*SCAN_DIV+1 cycles; never mid-frame.
- rst mid-frame: next cycle all state at reset values, outputs inactive; pending load discarded.

## Structure
- Shared package/include: glyph constants for 0–F, polarity helper constants, SCAN_DIV legality check.
- One sub-module: existing sm_hex_display (nibble → 7-bit active-high glyph), instantiated once on the muxed nibble; polarity inversion applied in the output register stage.
- Prescaler, idx counter, shadow registers and blanking logic live in the top.

## Test plan
- DIGITS=4, SCAN_DIV=16, all params default: rst 3 cycles → seg=7'h7F, dig_sel=4'hF; en=1 → dig_sel=4'b1110 for first slot, then 1101, 1011, 0111, frame_done every 64 cycles.
- load value=16'h00A5, dp=0, brightness=15 → after frame_done, digits 3,2 dark; digit1 seg=~7'b1110111; digit0 seg=~7'b1101101.
- load 16'h1234 at cnt=5 of idx=1 → display unchanged until frame_done, then shows 1234; load at wrap cycle → applied same frame.
- brightness=3 → digit active exactly cycles cnt=1..3 of each slot; brightness=15 → cnt=1..15; cnt=0 always dark.
- value=16'h0000, dp=4'b0100 → digits 3 dark, digit 2 shows 0 with dp lit, digits 1,0 show 0.
- en=0 at cnt=7 for 20 cycles → outputs inactive, cnt holds 7; en=1 resumes same idx; rst mid-slot → outputs inactive next cycle, idx=0.
